async_fifo_gray: RTL and testbench

Parametrised dual-clock FIFO that replaces the shared-counter design with Gray-coded pointer synchronisation between independent write and read clock domains. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, per-domain fill levels, registered read data with a valid strobe, and sticky overflow/underflow error flags. It sits between producer logic on clk_w and consumer logic on clk_r, which may be unrelated in phase and frequency.

---
 rtl/async_fifo_gray_if.sv | 32 +++
 rtl/async_fifo_gray.sv | 114 +++++++++++
 tb/tb_async_fifo_gray.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_gray_if.sv
// Write/read handshake and status bundle for async_fifo_gray.
// The producer/consumer side takes master; the FIFO takes slave.
interface async_fifo_gray_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
);
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              almost_full;
   logic [ADDR_W:0]   wr_level;
   logic              overflow;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              almost_empty;
   logic [ADDR_W:0]   rd_level;
   logic              underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  full, almost_full, wr_level, overflow,
      input  rd_data, rd_valid, empty, almost_empty, rd_level, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output full, almost_full, wr_level, overflow,
      output rd_data, rd_valid, empty, almost_empty, rd_level, underflow
   );
endinterface

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointer crossing, fill levels, thresholds
// and sticky overflow/underflow flags. rst is clk_w-synchronous; clk_r gets a synchronised copy.
module async_fifo_gray #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned AF_THRESH = (2 ** ADDR_W) - 4,
   parameter int unsigned AE_THRESH = 4
) (
   input  logic             clk_w,
   input  logic             clk_r,
   input  logic             rst,
   async_fifo_gray_if.slave bus
);
   localparam int unsigned      PTR_W  = ADDR_W + 1;
   localparam int unsigned      DEPTH  = 2 ** ADDR_W;
   localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
   localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

   function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
      logic [PTR_W-1:0] b;
      b = '0;
      for (int i = 0; i < PTR_W; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wptr_bin, wptr_gray, rq1_gray, rq2_gray;
   logic [PTR_W-1:0] rptr_bin, rptr_gray, wq1_gray, wq2_gray;
   logic             rst_meta, rst_r;

   logic             wr_accept_c, rd_accept_c;
   logic [PTR_W-1:0] wptr_bin_nxt_c, wptr_gray_nxt_c, wr_level_nxt_c;
   logic [PTR_W-1:0] rptr_bin_nxt_c, rptr_gray_nxt_c, rd_level_nxt_c;

   // Write-domain next pointer and level
   always_comb begin
      wr_accept_c     = bus.wr_en && !bus.full && !rst;
      wptr_bin_nxt_c  = wptr_bin + PTR_W'(wr_accept_c);
      wptr_gray_nxt_c = bin2gray(wptr_bin_nxt_c);
      wr_level_nxt_c  = wptr_bin_nxt_c - gray2bin(rq2_gray);
   end

   always_ff @(posedge clk_w) begin
      if (wr_accept_c) mem[wptr_bin[ADDR_W-1:0]] <= bus.wr_data;
   end

   always_ff @(posedge clk_w) begin
      if (rst) begin
         wptr_bin        <= '0;
         wptr_gray       <= '0;
         rq1_gray        <= '0;
         rq2_gray        <= '0;
         bus.full        <= 1'b0;
         bus.almost_full <= (AF_LVL == '0);
         bus.wr_level    <= '0;
         bus.overflow    <= 1'b0;
      end else begin
         wptr_bin        <= wptr_bin_nxt_c;
         wptr_gray       <= wptr_gray_nxt_c;
         rq1_gray        <= rptr_gray;
         rq2_gray        <= rq1_gray;
         // Full when the write pointer is one lap ahead: top two Gray bits differ.
         bus.full        <= (wptr_gray_nxt_c == {~rq2_gray[PTR_W-1 -: 2], rq2_gray[PTR_W-3:0]});
         bus.almost_full <= (wr_level_nxt_c >= AF_LVL);
         bus.wr_level    <= wr_level_nxt_c;
         if (bus.wr_en && bus.full) bus.overflow <= 1'b1;
      end
   end

   // Read-domain reset is rst passed through two clk_r flops.
   always_ff @(posedge clk_r) begin
      rst_meta <= rst;
      rst_r    <= rst_meta;
   end

   always_comb begin
      rd_accept_c     = bus.rd_en && !bus.empty;
      rptr_bin_nxt_c  = rptr_bin + PTR_W'(rd_accept_c);
      rptr_gray_nxt_c = bin2gray(rptr_bin_nxt_c);
      rd_level_nxt_c  = gray2bin(wq2_gray) - rptr_bin_nxt_c;
   end

   always_ff @(posedge clk_r) begin
      if (rst_r) begin
         rptr_bin         <= '0;
         rptr_gray        <= '0;
         wq1_gray         <= '0;
         wq2_gray         <= '0;
         bus.rd_data      <= '0;
         bus.rd_valid     <= 1'b0;
         bus.empty        <= 1'b1;
         bus.almost_empty <= 1'b1;
         bus.rd_level     <= '0;
         bus.underflow    <= 1'b0;
      end else begin
         rptr_bin         <= rptr_bin_nxt_c;
         rptr_gray        <= rptr_gray_nxt_c;
         wq1_gray         <= wptr_gray;
         wq2_gray         <= wq1_gray;
         bus.empty        <= (rptr_gray_nxt_c == wq2_gray);
         bus.almost_empty <= (rd_level_nxt_c <= AE_LVL);
         bus.rd_level     <= rd_level_nxt_c;
         bus.rd_valid     <= rd_accept_c;
         if (rd_accept_c) bus.rd_data <= mem[rptr_bin[ADDR_W-1:0]];
         if (bus.rd_en && bus.empty) bus.underflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_async_fifo_gray.sv
// Bench for async_fifo_gray: write/read vector tables, reset corner sequences,
// and a scoreboarded random stream at two clock ratios.
module tb_async_fifo_gray;
   localparam int unsigned DW     = 8;
   localparam int unsigned AW     = 4;
   localparam int unsigned LW     = AW + 1;
   localparam int          NWORDS = 2000;

   typedef struct {
      logic          wr_en;
      logic [DW-1:0] wr_data;
      logic          exp_full;
      logic          exp_af;
      logic [LW-1:0] exp_level;
      logic          exp_ovf;
   } wvec_t;

   typedef struct {
      logic          rd_en;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic          exp_empty;
      logic          exp_ae;
      logic [LW-1:0] exp_level;
   } rvec_t;

   logic clk_w = 1'b0;
   logic clk_r = 1'b0;
   logic rst   = 1'b1;
   int   half_w = 10;
   int   half_r = 23;
   int   total  = 0;
   int   bad    = 0;
   logic [DW-1:0] sb [$];

   async_fifo_gray_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   async_fifo_gray #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(12), .AE_THRESH(3)) dut (
      .clk_w (clk_w),
      .clk_r (clk_r),
      .rst   (rst),
      .bus   (bus)
   );

   initial forever #(half_w) clk_w = ~clk_w;
   initial forever #(half_r) clk_r = ~clk_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic sb_check(input string name);
      logic [DW-1:0] e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: rd_valid with nothing expected, got %0h", name, bus.rd_data);
      end else begin
         e = sb.pop_front();
         check(name, bus.rd_data, e);
      end
   endtask

   task automatic do_reset();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      @(posedge clk_w); #1 rst = 1'b1;
      repeat (4) @(posedge clk_r);
      @(posedge clk_w); #1 rst = 1'b0;
      repeat (4) @(posedge clk_r);
      #1;
      sb.delete();
   endtask

   task automatic write_one(input logic [DW-1:0] d);
      @(posedge clk_w); #1;
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      @(posedge clk_w); #1;
      bus.wr_en   = 1'b0;
   endtask

   task automatic traffic(input int hw, input int hr);
      int sent, got, rcyc, wcyc;
      half_w = hw;
      half_r = hr;
      do_reset();
      sent = 0;
      got  = 0;
      fork
         begin
            wcyc = 0;
            @(posedge clk_w); #1;
            while (sent < NWORDS && wcyc < 30000) begin
               if (!bus.full && ($urandom_range(3) != 0)) begin
                  bus.wr_en   = 1'b1;
                  bus.wr_data = DW'($urandom);
                  sb.push_back(bus.wr_data);
                  sent++;
               end else begin
                  bus.wr_en = 1'b0;
               end
               @(posedge clk_w); #1;
               wcyc++;
            end
            bus.wr_en = 1'b0;
         end
         begin
            rcyc = 0;
            @(posedge clk_r); #1;
            while (got < NWORDS && rcyc < 20000) begin
               if (bus.rd_valid) begin
                  sb_check("stream_data");
                  got++;
               end
               bus.rd_en = !bus.empty && ($urandom_range(3) != 0);
               @(posedge clk_r); #1;
               rcyc++;
            end
            bus.rd_en = 1'b0;
         end
      join
      check("stream_sent", sent, NWORDS);
      check("stream_got", got, NWORDS);
      check("stream_leftover", sb.size(), 0);
      check("stream_overflow", bus.overflow, 1'b0);
      check("stream_underflow", bus.underflow, 1'b0);
      check("stream_wraps_ge30", (got / 32) >= 30, 1'b1);
   endtask

   initial begin
      wvec_t wv [17];
      rvec_t rv [17];
      int    lvl, r, k;

      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;

      // Write table: 16 fills then one overflowing write, reads held off.
      for (int i = 0; i < 17; i++) begin
         lvl = (i < 16) ? i + 1 : 16;
         wv[i].wr_en     = 1'b1;
         wv[i].wr_data   = (i == 16) ? 8'hEE : DW'(i);
         wv[i].exp_full  = (lvl == 16);
         wv[i].exp_af    = (lvl >= 12);
         wv[i].exp_level = LW'(lvl);
         wv[i].exp_ovf   = (i == 16);
      end
      // Read table: 16 reads with one idle slot in the middle.
      r = 0;
      for (int i = 0; i < 17; i++) begin
         rv[i].rd_en     = (i != 8);
         rv[i].exp_valid = (i != 8);
         if (i != 8) r++;
         rv[i].exp_data  = DW'(r - 1);
         rv[i].exp_level = LW'(16 - r);
         rv[i].exp_empty = (r == 16);
         rv[i].exp_ae    = ((16 - r) <= 3);
      end

      do_reset();
      check("rst_full", bus.full, 1'b0);
      check("rst_almost_full", bus.almost_full, 1'b0);
      check("rst_wr_level", bus.wr_level, 0);
      check("rst_overflow", bus.overflow, 1'b0);
      check("rst_empty", bus.empty, 1'b1);
      check("rst_almost_empty", bus.almost_empty, 1'b1);
      check("rst_rd_level", bus.rd_level, 0);
      check("rst_rd_valid", bus.rd_valid, 1'b0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_underflow", bus.underflow, 1'b0);

      @(posedge clk_w); #1;
      for (int i = 0; i < 17; i++) begin
         bus.wr_en   = wv[i].wr_en;
         bus.wr_data = wv[i].wr_data;
         @(posedge clk_w); #1;
         check("wr_full", bus.full, wv[i].exp_full);
         check("wr_almost_full", bus.almost_full, wv[i].exp_af);
         check("wr_level", bus.wr_level, wv[i].exp_level);
         check("wr_overflow", bus.overflow, wv[i].exp_ovf);
      end
      bus.wr_en = 1'b0;

      repeat (5) @(posedge clk_r);
      #1;
      check("pre_rd_level", bus.rd_level, 16);
      check("pre_rd_empty", bus.empty, 1'b0);
      check("pre_rd_almost_empty", bus.almost_empty, 1'b0);

      for (int i = 0; i < 17; i++) begin
         bus.rd_en = rv[i].rd_en;
         @(posedge clk_r); #1;
         check("rd_valid", bus.rd_valid, rv[i].exp_valid);
         check("rd_data", bus.rd_data, rv[i].exp_data);
         check("rd_empty", bus.empty, rv[i].exp_empty);
         check("rd_almost_empty", bus.almost_empty, rv[i].exp_ae);
         check("rd_level", bus.rd_level, rv[i].exp_level);
      end
      bus.rd_en = 1'b0;

      k = 0;
      while (bus.wr_level != 0 && k < 10) begin
         @(posedge clk_w); #1;
         k++;
      end
      check("drain_wr_level", bus.wr_level, 0);
      check("drain_full", bus.full, 1'b0);
      check("overflow_sticky", bus.overflow, 1'b1);
      check("drain_underflow", bus.underflow, 1'b0);

      do_reset();
      check("rst2_overflow", bus.overflow, 1'b0);
      check("rst2_empty", bus.empty, 1'b1);
      check("rst2_rd_data", bus.rd_data, 0);

      // Read attempt on an empty FIFO.
      bus.rd_en = 1'b1;
      @(posedge clk_r); #1;
      bus.rd_en = 1'b0;
      @(posedge clk_r); #1;
      check("uf_rd_valid", bus.rd_valid, 1'b0);
      check("uf_rd_data", bus.rd_data, 0);
      check("uf_underflow", bus.underflow, 1'b1);
      check("uf_empty", bus.empty, 1'b1);

      // Reset with 9 entries held, then one fresh word.
      do_reset();
      @(posedge clk_w); #1;
      for (int i = 0; i < 9; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = DW'(8'h30 + i);
         @(posedge clk_w); #1;
      end
      bus.wr_en = 1'b0;
      repeat (5) @(posedge clk_r);
      #1;
      check("held_rd_level", bus.rd_level, 9);
      check("held_wr_level", bus.wr_level, 9);
      do_reset();
      check("mid_wr_level", bus.wr_level, 0);
      check("mid_rd_level", bus.rd_level, 0);
      check("mid_empty", bus.empty, 1'b1);
      check("mid_underflow", bus.underflow, 1'b0);

      write_one(8'hA5);
      sb.push_back(8'hA5);
      k = 0;
      do begin
         @(posedge clk_r); #1;
         k++;
      end while (bus.empty && k < 8);
      check("empty_fall_latency_ok", (k >= 2) && (k <= 4), 1'b1);
      bus.rd_en = 1'b1;
      @(posedge clk_r); #1;
      bus.rd_en = 1'b0;
      check("a5_rd_valid", bus.rd_valid, 1'b1);
      if (bus.rd_valid) sb_check("a5_rd_data");
      @(posedge clk_r); #1;
      check("a5_valid_pulse", bus.rd_valid, 1'b0);
      check("a5_empty", bus.empty, 1'b1);

      traffic(7, 13);
      traffic(13, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
